// File: rtl/dac_tlv5618_seq_if.sv
// Handshake and frame-engine bus for the TLV5618 sequencer.
// The slave modport is the sequencer. The master modport is the upstream source combined with the frame engine.
interface dac_tlv5618_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        spd;
  logic        dac_start;
  logic [15:0] dac_data;
  logic        dac_done;

  modport master (
    output in_valid, in_a, in_b, spd, dac_done,
    input  in_ready, dac_start, dac_data
  );

  modport slave (
    input  in_valid, in_a, in_b, spd, dac_done,
    output in_ready, dac_start, dac_data
  );
endinterface

// File: rtl/dac_tlv5618_seq.sv
// Sequencer for the TLV5618 frame engine. For each sample pair it issues a B-buffer write,
// then an A write that also updates B. Define DAC_SEQ_PACE_EN to accept pairs at a fixed tick rate.
module dac_tlv5618_seq #(
  parameter int GapCycles     = 2,
  parameter int TimeoutCycles = 1023,
  parameter int PaceDiv       = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dac_tlv5618_seq_if.slave         bus,
  output logic                     busy,
  output logic                     pair_done,
  output logic                     err,
  output logic                     late
);

  typedef enum logic [2:0] {
    S_IDLE, S_START_B, S_WAIT_B, S_GAP, S_START_A, S_WAIT_A
  } state_t;

  localparam logic [9:0] GAP_LAST = 10'(GapCycles - 1);
  localparam logic [9:0] TO_LAST  = 10'(TimeoutCycles - 1);

  state_t      r_state, w_next;
  logic [9:0]  r_cnt;
  logic [11:0] r_a, r_b;
  logic        r_spd;
  logic        r_gap_to_a, w_gap_to_a;
  logic        r_dac_start;
  logic [15:0] r_dac_data;
  logic        r_pair_done, w_pair_done;
  logic        r_err, w_err;
  logic        w_in_ready, w_accept;

  assign w_accept = bus.in_valid && w_in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_gap_to_a  = r_gap_to_a;
    w_pair_done = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_START_B;
      S_START_B: w_next = S_WAIT_B;
      S_WAIT_B: begin
        if (bus.dac_done) begin
          w_next     = S_GAP;
          w_gap_to_a = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_next     = S_GAP;
          w_gap_to_a = 1'b0;
          w_err      = 1'b1;
        end
      end
      S_GAP:     if (r_cnt == GAP_LAST) w_next = r_gap_to_a ? S_START_A : S_IDLE;
      S_START_A: w_next = S_WAIT_A;
      S_WAIT_A: begin
        if (bus.dac_done) begin
          w_next      = S_GAP;
          w_gap_to_a  = 1'b0;
          w_pair_done = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_next     = S_GAP;
          w_gap_to_a = 1'b0;
          w_err      = 1'b1;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_spd       <= 1'b0;
      r_gap_to_a  <= 1'b0;
      r_dac_start <= 1'b0;
      r_dac_data  <= '0;
      r_pair_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Counter restarts on each state entry and serves both as the timeout count and the gap count.
      r_cnt       <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 10'd1;
      r_gap_to_a  <= w_gap_to_a;
      r_pair_done <= w_pair_done;
      r_err       <= w_err;
      r_dac_start <= (w_next == S_START_B) || (w_next == S_START_A);
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_spd <= bus.spd;
      end
      // The B word is built from the live inputs because the pair is latched on this same edge.
      if (w_next == S_START_B)
        r_dac_data <= {1'b0, bus.spd, 1'b0, 1'b1, bus.in_b};
      else if (w_next == S_START_A)
        r_dac_data <= {1'b1, r_spd, 1'b0, 1'b0, r_a};
    end
  end

`ifdef DAC_SEQ_PACE_EN
  localparam int PW = $clog2(PaceDiv);
  logic [PW-1:0] r_pace_cnt;
  logic          r_pend, r_late;
  logic          w_tick;

  assign w_tick = (r_pace_cnt == PW'(PaceDiv - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pace_cnt <= '0;
      r_pend     <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_pace_cnt <= w_tick ? '0 : r_pace_cnt + 1'b1;
      if (w_tick)        r_pend <= 1'b1;
      else if (w_accept) r_pend <= 1'b0;
      r_late     <= w_tick && r_pend && !w_accept;
    end
  end

  assign w_in_ready = (r_state == S_IDLE) && r_pend;
  assign late       = r_late;
`else
  assign w_in_ready = (r_state == S_IDLE);
  assign late       = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.dac_start = r_dac_start;
  assign bus.dac_data  = r_dac_data;
  assign busy          = (r_state != S_IDLE);
  assign pair_done     = r_pair_done;
  assign err           = r_err;

endmodule

// File: tb/tb_dac_tlv5618_seq.sv
// Directed bench for dac_tlv5618_seq. A behavioural frame engine answers each start with a done pulse after a programmable delay.
module tb_dac_tlv5618_seq;
  localparam int G = 2;
  localparam int T = 15;

  logic clk, rst_n;
  logic busy, pair_done, err, late;
  dac_tlv5618_seq_if bus ();

  dac_tlv5618_seq #(.GapCycles(G), .TimeoutCycles(T), .PaceDiv(50)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .busy(busy), .pair_done(pair_done), .err(err), .late(late)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          start_cyc[$];
  logic [15:0] start_data[$];
  int          done_cyc[$];
  int          pd_cyc[$];
  int          err_cyc[$];
  int          late_cyc[$];
  int          overlap = 0;

  bit eng_en    = 1'b1;
  int eng_delay = 3;
  int eng_cnt   = 0;
  int inj_req   = 0;
  int inj_ack   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and frame-engine model share one negedge process so their ordering is fixed.
  always @(negedge clk) begin
    if (bus.dac_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(bus.dac_data);
    end
    if (pair_done) pd_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
    if (late) late_cyc.push_back(cyc);
    if (busy && bus.in_ready) overlap++;
    if (bus.dac_done) bus.dac_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.dac_done = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
    if (bus.dac_start && eng_en) eng_cnt = eng_delay;
    if (inj_req != inj_ack) begin
      bus.dac_done = 1'b1;
      inj_ack = inj_req;
    end
  end

  task automatic clear_log();
    @(posedge clk); #1;
    start_cyc.delete(); start_data.delete(); done_cyc.delete();
    pd_cyc.delete(); err_cyc.delete(); late_cyc.delete();
    overlap = 0;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic s, output int acc);
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.spd = s; bus.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.in_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (acc < 0) begin errors++; $display("FAIL send_accept: not accepted within 2000 cycles"); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle: busy still %b after 500 cycles", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.spd = 1'b0; bus.dac_done = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.dac_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", bus.dac_start); end
    if (bus.dac_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", bus.dac_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (pair_done !== 1'b0) begin errors++; $display("FAIL rst_pair_done: got %b want 0", pair_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    if (late !== 1'b0) begin errors++; $display("FAIL rst_late: got %b want 0", late); end
    rst_n = 1'b1;
    @(negedge clk);
`ifndef DAC_SEQ_PACE_EN
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
`endif
  endtask

  task automatic test_pair();
    int a;
    eng_en = 1'b1; eng_delay = 3;
    clear_log();
    send(12'h800, 12'h123, 1'b1, a);
    wait_idle();
    checks++;
    if (start_cyc.size() != 2) begin errors++; $display("FAIL pair_starts: got %0d want 2", start_cyc.size()); end
    else begin
      checks += 4;
      if (start_data[0] !== 16'h5123) begin errors++; $display("FAIL pair_word_b: got %h want 5123", start_data[0]); end
      if (start_data[1] !== 16'hC800) begin errors++; $display("FAIL pair_word_a: got %h want c800", start_data[1]); end
      if (start_cyc[0] != a + 1) begin errors++; $display("FAIL pair_lat_b: got %0d want %0d", start_cyc[0], a + 1); end
      if (start_cyc[1] != a + 7) begin errors++; $display("FAIL pair_lat_a: got %0d want %0d", start_cyc[1], a + 7); end
    end
    checks++;
    if (pd_cyc.size() != 1) begin errors++; $display("FAIL pair_done_cnt: got %0d want 1", pd_cyc.size()); end
    else begin
      checks++;
      if (pd_cyc[0] != a + 11) begin errors++; $display("FAIL pair_done_cyc: got %0d want %0d", pd_cyc[0], a + 11); end
    end
    checks++;
    if (err_cyc.size() != 0) begin errors++; $display("FAIL pair_err: got %0d pulses want 0", err_cyc.size()); end
  endtask

  task automatic test_spacing();
    int a;
    eng_en = 1'b1; eng_delay = 5;
    clear_log();
    send(12'hFFF, 12'h000, 1'b0, a);
    wait_idle();
    checks++;
    if (start_cyc.size() != 2 || done_cyc.size() != 2) begin
      errors++; $display("FAIL space_count: starts %0d dones %0d want 2 2", start_cyc.size(), done_cyc.size());
    end else begin
      checks += 4;
      if (start_data[0] !== 16'h1000) begin errors++; $display("FAIL space_word_b: got %h want 1000", start_data[0]); end
      if (start_data[1] !== 16'h8FFF) begin errors++; $display("FAIL space_word_a: got %h want 8fff", start_data[1]); end
      if (done_cyc[0] != a + 6) begin errors++; $display("FAIL space_done: got %0d want %0d", done_cyc[0], a + 6); end
      if (start_cyc[1] != done_cyc[0] + G + 1) begin
        errors++; $display("FAIL space_gap: start %0d want %0d", start_cyc[1], done_cyc[0] + G + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accs[2];
    int n;
    eng_en = 1'b1; eng_delay = 2;
    clear_log();
    n = 0;
    @(negedge clk);
    bus.in_a = 12'h111; bus.in_b = 12'h222; bus.spd = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3000 && n < 2; i++) begin
      if (bus.in_ready) begin
        accs[n] = cyc; n++;
        @(negedge clk);
        if (n == 1) begin bus.in_a = 12'h333; bus.in_b = 12'h444; bus.spd = 1'b0; end
      end else @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle();
    checks += 3;
    if (n != 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", n); end
    if (overlap != 0) begin errors++; $display("FAIL b2b_ready_busy: in_ready high while busy %0d cycles", overlap); end
    if (start_cyc.size() != 4) begin errors++; $display("FAIL b2b_starts: got %0d want 4", start_cyc.size()); end
    else begin
      checks += 5;
      if (start_data[0] !== 16'h5222) begin errors++; $display("FAIL b2b_w0: got %h want 5222", start_data[0]); end
      if (start_data[1] !== 16'hC111) begin errors++; $display("FAIL b2b_w1: got %h want c111", start_data[1]); end
      if (start_data[2] !== 16'h1444) begin errors++; $display("FAIL b2b_w2: got %h want 1444", start_data[2]); end
      if (start_data[3] !== 16'h8333) begin errors++; $display("FAIL b2b_w3: got %h want 8333", start_data[3]); end
      if (n == 2 && start_cyc[2] != accs[1] + 1) begin
        errors++; $display("FAIL b2b_lat: got %0d want %0d", start_cyc[2], accs[1] + 1);
      end
    end
`ifndef DAC_SEQ_PACE_EN
    checks++;
    if (n == 2 && accs[1] != accs[0] + 11) begin
      errors++; $display("FAIL b2b_reaccept: got %0d want %0d", accs[1], accs[0] + 11);
    end
`endif
  endtask

  task automatic test_timeout();
    int a;
    eng_en = 1'b0;
    clear_log();
    send(12'h0AA, 12'h055, 1'b0, a);
    wait_idle();
    checks += 3;
    if (start_cyc.size() != 1) begin errors++; $display("FAIL to_starts: got %0d want 1", start_cyc.size()); end
    if (pd_cyc.size() != 0) begin errors++; $display("FAIL to_pair_done: got %0d want 0", pd_cyc.size()); end
    if (err_cyc.size() != 1) begin errors++; $display("FAIL to_err_cnt: got %0d want 1", err_cyc.size()); end
    else begin
      checks++;
      if (err_cyc[0] != a + 2 + T) begin errors++; $display("FAIL to_err_cyc: got %0d want %0d", err_cyc[0], a + 2 + T); end
    end
    eng_en = 1'b1;
  endtask

  task automatic test_done_ignored();
    clear_log();
    @(negedge clk);
    inj_req++;
    repeat (10) @(negedge clk);
    checks += 3;
    if (start_cyc.size() != 0) begin errors++; $display("FAIL ign_starts: got %0d want 0", start_cyc.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy); end
    if (pd_cyc.size() != 0) begin errors++; $display("FAIL ign_pair_done: got %0d want 0", pd_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int a;
    eng_en = 1'b0;
    clear_log();
    send(12'h7FF, 12'h3C3, 1'b1, a);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (bus.dac_data !== 16'h0000) begin errors++; $display("FAIL mid_data: got %h want 0000", bus.dac_data); end
    if (bus.dac_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", bus.dac_start); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef DAC_SEQ_PACE_EN
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
`endif
    clear_log();
    repeat (25) @(negedge clk);
    checks += 2;
    if (start_cyc.size() != 0) begin errors++; $display("FAIL mid_no_start: got %0d want 0", start_cyc.size()); end
    if (err_cyc.size() != 0) begin errors++; $display("FAIL mid_no_err: got %0d want 0", err_cyc.size()); end
    eng_en = 1'b1;
  endtask

`ifdef DAC_SEQ_PACE_EN
  task automatic test_pace();
    int accs[3];
    int n;
    eng_en = 1'b1; eng_delay = 2;
    clear_log();
    n = 0;
    @(negedge clk);
    bus.in_a = 12'h456; bus.in_b = 12'h789; bus.spd = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3000 && n < 3; i++) begin
      if (bus.in_ready) begin accs[n] = cyc; n++; end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    late_cyc.delete();
    repeat (120) @(negedge clk);
    checks += 3;
    if (n != 3) begin errors++; $display("FAIL pace_accepts: got %0d want 3", n); end
    if (n == 3 && (accs[1] - accs[0] != 50 || accs[2] - accs[1] != 50)) begin
      errors++; $display("FAIL pace_spacing: got %0d %0d want 50 50", accs[1] - accs[0], accs[2] - accs[1]);
    end
    if (late_cyc.size() != 1) begin errors++; $display("FAIL pace_late_cnt: got %0d want 1", late_cyc.size()); end
    else begin
      checks++;
      if (late_cyc[0] != accs[2] + 100) begin
        errors++; $display("FAIL pace_late_cyc: got %0d want %0d", late_cyc[0], accs[2] + 100);
      end
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pair();
    test_spacing();
    test_back_to_back();
    test_timeout();
    test_done_ignored();
    test_reset_mid();
`ifdef DAC_SEQ_PACE_EN
    test_pace();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
